// File: rtl/seq6_state_ctrl.sv
// seq6_state_ctrl: registered six-state w-driven sequencer with handshake, loads, entry counter and sticky error
module seq6_state_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             w_valid,
   input  logic             w,
   output logic             w_ready,
   input  logic             enable,
   input  logic             load_en,
   input  logic [2:0]       load_state,
   input  logic             count_clr,
   output logic [2:0]       state,
   output logic             z,
   output logic             hit_pulse,
   output logic [CNT_W-1:0] hit_count,
   output logic             err
);
   typedef enum logic [2:0] {
      S_A = 3'b000,
      S_B = 3'b001,
      S_C = 3'b010,
      S_D = 3'b011,
      S_E = 3'b100,
      S_F = 3'b101
   } state_t;

   state_t cur, nxt;
   logic xfer, load_bad, entry;

   // next state from load or accepted sample; entry flags C/D moving into E/F
   always_comb begin
      w_ready  = enable & ~load_en;
      xfer     = w_valid & w_ready;
      load_bad = load_state[2] & load_state[1];
      entry    = xfer & ~w & (cur == S_C || cur == S_D);
      nxt      = cur;
      if (load_en)
         nxt = load_bad ? S_A : state_t'(load_state);
      else if (xfer)
         case (cur)
            S_A:     nxt = w ? S_A : S_B;
            S_B:     nxt = w ? S_D : S_C;
            S_C:     nxt = w ? S_D : S_E;
            S_D:     nxt = w ? S_A : S_F;
            S_E:     nxt = w ? S_D : S_E;
            S_F:     nxt = w ? S_D : S_C;
            default: nxt = S_A;
         endcase
   end

   // state register, entry pulse, saturating entry counter and sticky error
   always_ff @(posedge clk) begin
      if (reset) begin
         cur       <= S_A;
         hit_pulse <= 1'b0;
         hit_count <= '0;
         err       <= 1'b0;
      end else begin
         cur       <= nxt;
         hit_pulse <= entry;
         if (count_clr)
            hit_count <= '0;
         else if (entry && hit_count != '1)
            hit_count <= hit_count + 1'b1;
         if (load_en && load_bad)
            err <= 1'b1;
      end
   end

   assign state = cur;
   assign z     = (cur == S_E) || (cur == S_F);
endmodule
